telem_ft_tx_sched: RTL and testbench
====================================

TELEM_FT_TX_SCHED -- requirements
Module: telem_ft_tx_sched

Interface
REQ-001 SHALL have parameter PERIOD, default 32'd256000000, clock cycles between automatic stats frames.
REQ-002 SHALL have parameter HDR_PKT, default 16'hA55A, first word of a packet frame.
REQ-003 SHALL have parameter HDR_STAT, default 16'h5AA5, first word of a stats frame.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port pkt_data  in  88  unpacked telemetry packet.
REQ-007 SHALL have port pkt_valid  in  1  pkt_data valid, one-cycle pulse per packet.
REQ-008 SHALL have port total_packets  in  32  checker packet count.
REQ-009 SHALL have port mismatch_packets  in  32  checker mismatch count.
REQ-010 SHALL have port stat_req  in  1  pulse requesting an immediate stats frame.
REQ-011 SHALL have port ui_din  out  16  word to FT TX FIFO.
REQ-012 SHALL have port ui_din_be  out  2  byte enables; be[1]=ui_din[15:8], be[0]=ui_din[7:0].
REQ-013 SHALL have port ui_din_valid  out  1  ui_din holds a word.
REQ-014 SHALL have port ui_din_full  in  1  FT TX FIFO full; backpressure.
REQ-015 SHALL have port drop_count  out  16  packets lost to a full holding register.
REQ-016 SHALL have port busy  out  1  high whenever FSM is not IDLE.

Function
REQ-017 SHALL transfer a word in any cycle where ui_din_valid=1 and ui_din_full=0; ui_din/ui_din_be SHALL stay stable while ui_din_valid=1 and ui_din_full=1.
REQ-018 SHALL capture pkt_data into a one-entry holding register on pkt_valid when holding is empty, or is freed in the same cycle (last PKT word transferring).
REQ-019 SHALL increment drop_count, saturating at 16'hFFFF, on pkt_valid while holding is full and not being freed.
REQ-020 SHALL run a free-running timer 0..PERIOD-1, wrapping to 0; wrap or stat_req SHALL set stat_pending.
REQ-021 SHALL snapshot total_packets and mismatch_packets when stat_pending goes 0->1; a request while already pending SHALL be coalesced (no new snapshot).
REQ-022 SHALL implement FSM states IDLE, PKT, STAT; all outputs registered.
REQ-023 IDLE: only holding full -> PKT; only stat_pending -> STAT; both -> opposite of last_grant; neither -> stay; ui_din_valid=0 in IDLE.
REQ-024 PKT frame SHALL be 7 words, be=2'b11 unless noted: HDR_PKT, pkt_data[87:72], [71:56], [55:40], [39:24], [23:8], then {pkt_data[7:0],8'h00} with be=2'b10.
REQ-025 STAT frame SHALL be 6 words, be=2'b11: HDR_STAT, total[31:16], total[15:0], mismatch[31:16], mismatch[15:0], drop_count value at header transfer.
REQ-026 On transfer of a frame's last word, FSM SHALL return to IDLE, free holding (PKT) or clear stat_pending (STAT), and set last_grant to that frame type; frames separated by at least one idle cycle.
REQ-027 Latency: pkt_valid in cycle N with FSM IDLE and nothing pending -> header word with ui_din_valid=1 in cycle N+2.
REQ-028 Frames SHALL never interleave; a started frame completes regardless of new requests.

Reset
REQ-029 On rst, SHALL set FSM=IDLE, ui_din=0, ui_din_be=0, ui_din_valid=0, drop_count=0, busy=0, timer=0, holding empty, stat_pending=0, snapshots=0, last_grant=PKT.
REQ-030 rst mid-frame SHALL abandon the frame; no further words emitted; held packet discarded.

Verification
REQ-031 Single packet, ui_din_full=0, pkt_data=88'h0102..0B: 7 words A55A,0102,0304,0506,0708,090A,0B00; last be=2'b10; header in cycle N+2.
REQ-032 stat_req with total=32'h00001234, mismatch=32'h00000005, drop=0: 5AA5,0000,1234,0000,0005,0000.
REQ-033 ui_din_full=1 for 10 cycles mid-PKT frame: word and be unchanged throughout, no word lost or repeated.
REQ-034 pkt_valid and stat_req same cycle from reset: STAT frame first (last_grant=PKT), then PKT frame.
REQ-035 3 pkt_valid pulses during one stalled frame: drop_count=2; 70000 pulses with holding full: drop_count=16'hFFFF.
REQ-036 PERIOD=100, idle: stats frame every 100 cycles; rst asserted at word 3 of a PKT frame: ui_din_valid=0 next cycle, drop_count=0.

Source files
------------

// File: rtl/telem_ft_tx_sched_if.sv
// ---------------------------------------------------------------------------
// telem_ft_tx_sched_if
// Word stream from the telemetry scheduler into the FT TX FIFO.
//   ui_din       : 16-bit word offered to the FIFO
//   ui_din_be    : byte enables, be[1] -> ui_din[15:8], be[0] -> ui_din[7:0]
//   ui_din_valid : ui_din/ui_din_be hold a word
//   ui_din_full  : FIFO full; a word moves only when valid=1 and full=0
// master = scheduler side, slave = FIFO side.
// ---------------------------------------------------------------------------
interface telem_ft_tx_sched_if;
    logic [15:0] ui_din;
    logic [1:0]  ui_din_be;
    logic        ui_din_valid;
    logic        ui_din_full;

    modport master (
        output ui_din,
        output ui_din_be,
        output ui_din_valid,
        input  ui_din_full
    );

    modport slave (
        input  ui_din,
        input  ui_din_be,
        input  ui_din_valid,
        output ui_din_full
    );
endinterface

// File: rtl/telem_ft_tx_sched.sv
// ---------------------------------------------------------------------------
// telem_ft_tx_sched
// Frames telemetry packets and periodic/requested statistics into 16-bit
// words for the FT TX FIFO.
//   clk, rst          : single clock, synchronous active-high reset
//   pkt_data/valid    : 88-bit packet, one-cycle valid pulse per packet
//   total_packets     : checker packet count (snapshotted for stats)
//   mismatch_packets  : checker mismatch count (snapshotted for stats)
//   stat_req          : pulse requesting an immediate stats frame
//   ft (master)       : ui_din / ui_din_be / ui_din_valid / ui_din_full
//   drop_count        : packets lost to a full holding register (saturating)
//   busy              : FSM is sending a frame
// Packet frame : HDR_PKT + 6 data words (last word upper byte only).
// Stats frame  : HDR_STAT + total(2) + mismatch(2) + drop_count.
// ---------------------------------------------------------------------------
module telem_ft_tx_sched #(
    parameter logic [31:0] PERIOD   = 32'd256000000,
    parameter logic [15:0] HDR_PKT  = 16'hA55A,
    parameter logic [15:0] HDR_STAT = 16'h5AA5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [87:0]         pkt_data,
    input  logic                pkt_valid,
    input  logic [31:0]         total_packets,
    input  logic [31:0]         mismatch_packets,
    input  logic                stat_req,
    telem_ft_tx_sched_if.master ft,
    output logic [15:0]         drop_count,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PKT,
        ST_STAT
    } state_t;

    typedef enum logic {
        GRANT_PKT,
        GRANT_STAT
    } grant_t;

    localparam logic [2:0] PKT_LAST  = 3'd6;
    localparam logic [2:0] STAT_LAST = 3'd5;

    // Word + byte enables for a packet frame position.
    function automatic logic [17:0] pkt_word(input logic [2:0]  idx,
                                             input logic [87:0] d);
        logic [17:0] w;
        case (idx)
            3'd0:    w = {HDR_PKT,         2'b11};
            3'd1:    w = {d[87:72],        2'b11};
            3'd2:    w = {d[71:56],        2'b11};
            3'd3:    w = {d[55:40],        2'b11};
            3'd4:    w = {d[39:24],        2'b11};
            3'd5:    w = {d[23:8],         2'b11};
            3'd6:    w = {d[7:0],  8'h00,  2'b10};
            default: w = 18'd0;
        endcase
        return w;
    endfunction

    // Word + byte enables for a stats frame position.
    function automatic logic [17:0] stat_word(input logic [2:0]  idx,
                                              input logic [31:0] tot,
                                              input logic [31:0] mis,
                                              input logic [15:0] drp);
        logic [17:0] w;
        case (idx)
            3'd0:    w = {HDR_STAT,    2'b11};
            3'd1:    w = {tot[31:16],  2'b11};
            3'd2:    w = {tot[15:0],   2'b11};
            3'd3:    w = {mis[31:16],  2'b11};
            3'd4:    w = {mis[15:0],   2'b11};
            3'd5:    w = {drp,         2'b11};
            default: w = 18'd0;
        endcase
        return w;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // FSM / output registers
    state_t      r_state;
    logic [2:0]  r_idx;
    logic [15:0] r_din;
    logic [1:0]  r_be;
    logic        r_valid;
    logic        r_busy;

    // Datapath / bookkeeping registers
    logic [87:0] r_hold_data;
    logic        r_hold_full;
    logic [15:0] r_drop_count;
    logic [15:0] r_drop_hdr;
    logic [31:0] r_timer;
    logic        r_stat_pending;
    logic [31:0] r_snap_total;
    logic [31:0] r_snap_mis;
    grant_t      r_last_grant;

    // Combinational next values
    state_t      w_state_nxt;
    logic [2:0]  w_idx_nxt;
    logic [17:0] w_word_nxt;
    logic        w_valid_nxt;

    logic w_xfer;
    logic w_pkt_last;
    logic w_stat_last;
    logic w_stat_hdr_xfer;
    logic w_capture;
    logic w_drop;
    logic w_wrap;
    logic w_stat_set;
    logic w_snap;

    assign w_xfer          = r_valid & ~ft.ui_din_full;
    assign w_pkt_last      = (r_state == ST_PKT)  & w_xfer & (r_idx == PKT_LAST);
    assign w_stat_last     = (r_state == ST_STAT) & w_xfer & (r_idx == STAT_LAST);
    assign w_stat_hdr_xfer = (r_state == ST_STAT) & w_xfer & (r_idx == 3'd0);

    // The holding slot is reusable in the very cycle its last word leaves.
    assign w_capture = pkt_valid & (~r_hold_full | w_pkt_last);
    assign w_drop    = pkt_valid &  r_hold_full & ~w_pkt_last;

    assign w_wrap     = (r_timer == PERIOD - 32'd1);
    assign w_stat_set = w_wrap | stat_req;
    // A request landing on the clearing cycle starts a fresh pending period,
    // so it gets a fresh snapshot; otherwise requests coalesce.
    assign w_snap     = w_stat_set & (~r_stat_pending | w_stat_last);

    assign ft.ui_din       = r_din;
    assign ft.ui_din_be    = r_be;
    assign ft.ui_din_valid = r_valid;
    assign drop_count      = r_drop_count;
    assign busy            = r_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_word_nxt  = {r_din, r_be};
        w_valid_nxt = r_valid;
        case (r_state)
            ST_IDLE: begin
                w_valid_nxt = 1'b0;
                w_word_nxt  = 18'd0;
                w_idx_nxt   = 3'd0;
                // Both pending: grant the type that did not go last.
                if (r_hold_full && (!r_stat_pending || r_last_grant == GRANT_STAT)) begin
                    w_state_nxt = ST_PKT;
                    w_word_nxt  = pkt_word(3'd0, r_hold_data);
                    w_valid_nxt = 1'b1;
                end else if (r_stat_pending) begin
                    w_state_nxt = ST_STAT;
                    w_word_nxt  = stat_word(3'd0, r_snap_total, r_snap_mis, r_drop_hdr);
                    w_valid_nxt = 1'b1;
                end
            end
            ST_PKT: begin
                if (w_xfer) begin
                    if (r_idx == PKT_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = 3'd0;
                        w_word_nxt  = 18'd0;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_idx_nxt  = r_idx + 3'd1;
                        w_word_nxt = pkt_word(r_idx + 3'd1, r_hold_data);
                    end
                end
            end
            ST_STAT: begin
                if (w_xfer) begin
                    if (r_idx == STAT_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = 3'd0;
                        w_word_nxt  = 18'd0;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_idx_nxt  = r_idx + 3'd1;
                        w_word_nxt = stat_word(r_idx + 3'd1, r_snap_total,
                                               r_snap_mis, r_drop_hdr);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = 3'd0;
                w_word_nxt  = 18'd0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 3'd0;
            r_din   <= 16'd0;
            r_be    <= 2'b00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_idx           <= w_idx_nxt;
            {r_din, r_be}   <= w_word_nxt;
            r_valid         <= w_valid_nxt;
            r_busy          <= (w_state_nxt != ST_IDLE);
        end
    end

    // Holding register, drop counter, stats timer and snapshots
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_data    <= 88'd0;
            r_hold_full    <= 1'b0;
            r_drop_count   <= 16'd0;
            r_drop_hdr     <= 16'd0;
            r_timer        <= 32'd0;
            r_stat_pending <= 1'b0;
            r_snap_total   <= 32'd0;
            r_snap_mis     <= 32'd0;
            r_last_grant   <= GRANT_PKT;
        end else begin
            if (w_capture) begin
                r_hold_data <= pkt_data;
                r_hold_full <= 1'b1;
            end else if (w_pkt_last) begin
                r_hold_full <= 1'b0;
            end

            if (w_drop) begin
                r_drop_count <= sat_inc16(r_drop_count);
            end

            r_timer <= w_wrap ? 32'd0 : r_timer + 32'd1;

            if (w_stat_set) begin
                r_stat_pending <= 1'b1;
            end else if (w_stat_last) begin
                r_stat_pending <= 1'b0;
            end

            if (w_snap) begin
                r_snap_total <= total_packets;
                r_snap_mis   <= mismatch_packets;
            end

            // Last stats word reports the drop count as seen at header time.
            if (w_stat_hdr_xfer) begin
                r_drop_hdr <= r_drop_count;
            end

            if (w_pkt_last) begin
                r_last_grant <= GRANT_PKT;
            end else if (w_stat_last) begin
                r_last_grant <= GRANT_STAT;
            end
        end
    end

endmodule

// File: tb/tb_telem_ft_tx_sched.sv
module tb_telem_ft_tx_sched;

    localparam logic [15:0] HP = 16'hA55A;
    localparam logic [15:0] HS = 16'h5AA5;

    logic        clk = 1'b0;
    logic        rst;
    logic [87:0] pkt_data;
    logic        pkt_valid;
    logic [31:0] total_packets;
    logic [31:0] mismatch_packets;
    logic        stat_req;
    logic [15:0] drop_count;
    logic        busy;
    logic [15:0] drop_count_p;
    logic        busy_p;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int xfer_cnt = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    telem_ft_tx_sched_if ft_if();
    telem_ft_tx_sched_if ft_if_p();
    assign ft_if_p.ui_din_full = 1'b0;

    telem_ft_tx_sched u_dut (
        .clk              (clk),
        .rst              (rst),
        .pkt_data         (pkt_data),
        .pkt_valid        (pkt_valid),
        .total_packets    (total_packets),
        .mismatch_packets (mismatch_packets),
        .stat_req         (stat_req),
        .ft               (ft_if),
        .drop_count       (drop_count),
        .busy             (busy)
    );

    telem_ft_tx_sched #(.PERIOD(32'd100)) u_dut_p (
        .clk              (clk),
        .rst              (rst),
        .pkt_data         (88'd0),
        .pkt_valid        (1'b0),
        .total_packets    (32'h0000_0011),
        .mismatch_packets (32'h0000_0022),
        .stat_req         (1'b0),
        .ft               (ft_if_p),
        .drop_count       (drop_count_p),
        .busy             (busy_p)
    );

    // Scoreboard: every word that moves into the FIFO is compared in order.
    always @(negedge clk) begin
        if (!rst && ft_if.ui_din_valid && !ft_if.ui_din_full) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL word_unexpected got=%h be=%b required=none", ft_if.ui_din, ft_if.ui_din_be);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({ft_if.ui_din, ft_if.ui_din_be} !== mon_exp) begin
                    failures++;
                    $display("FAIL word[%0d] got=%h be=%b required=%h be=%b", xfer_cnt,
                             ft_if.ui_din, ft_if.ui_din_be, mon_exp[17:2], mon_exp[1:0]);
                end
            end
            xfer_cnt++;
        end
    end

    function automatic void push_pkt(input logic [87:0] d);
        exp_q.push_back({HP, 2'b11});
        exp_q.push_back({d[87:72], 2'b11});
        exp_q.push_back({d[71:56], 2'b11});
        exp_q.push_back({d[55:40], 2'b11});
        exp_q.push_back({d[39:24], 2'b11});
        exp_q.push_back({d[23:8], 2'b11});
        exp_q.push_back({d[7:0], 8'h00, 2'b10});
    endfunction

    function automatic void push_stat(input logic [31:0] t, input logic [31:0] m,
                                      input logic [15:0] dr);
        exp_q.push_back({HS, 2'b11});
        exp_q.push_back({t[31:16], 2'b11});
        exp_q.push_back({t[15:0], 2'b11});
        exp_q.push_back({m[31:16], 2'b11});
        exp_q.push_back({m[15:0], 2'b11});
        exp_q.push_back({dr, 2'b11});
    endfunction

    function automatic logic [87:0] rand_pkt();
        return {24'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pkt_valid = 1'b0;
        stat_req = 1'b0;
        pkt_data = '0;
        total_packets = '0;
        mismatch_packets = '0;
        ft_if.ui_din_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ft_if.ui_din_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b required=0", ft_if.ui_din_valid); end
        checks++;
        if (ft_if.ui_din !== 16'h0000) begin failures++; $display("FAIL reset_din got=%h required=0000", ft_if.ui_din); end
        checks++;
        if (ft_if.ui_din_be !== 2'b00) begin failures++; $display("FAIL reset_be got=%b required=00", ft_if.ui_din_be); end
        checks++;
        if (drop_count !== 16'h0000) begin failures++; $display("FAIL reset_drop got=%h required=0000", drop_count); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_pkt();
        int n;
        int hdr_cyc;
        exp_q.push_back({16'hA55A, 2'b11});
        exp_q.push_back({16'h0102, 2'b11});
        exp_q.push_back({16'h0304, 2'b11});
        exp_q.push_back({16'h0506, 2'b11});
        exp_q.push_back({16'h0708, 2'b11});
        exp_q.push_back({16'h090A, 2'b11});
        exp_q.push_back({16'h0B00, 2'b10});
        tick();
        pkt_data = 88'h0102030405060708090A0B;
        pkt_valid = 1'b1;
        n = cyc;
        tick();
        pkt_valid = 1'b0;
        hdr_cyc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ft_if.ui_din_valid) begin
                hdr_cyc = cyc;
                break;
            end
        end
        checks++;
        if (hdr_cyc != n + 2) begin failures++; $display("FAIL pkt_latency got=%0d required=%0d", hdr_cyc - n, 2); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL pkt_busy got=%b required=1", busy); end
        wait_drain(50);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL pkt_drain left=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_stat();
        exp_q.push_back({16'h5AA5, 2'b11});
        exp_q.push_back({16'h0000, 2'b11});
        exp_q.push_back({16'h1234, 2'b11});
        exp_q.push_back({16'h0000, 2'b11});
        exp_q.push_back({16'h0005, 2'b11});
        exp_q.push_back({16'h0000, 2'b11});
        tick();
        total_packets = 32'h0000_1234;
        mismatch_packets = 32'h0000_0005;
        stat_req = 1'b1;
        tick();
        stat_req = 1'b0;
        total_packets = 32'hDEAD_BEEF;
        wait_drain(50);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL stat_drain left=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_stall();
        logic [87:0] d;
        logic [17:0] held;
        int base;
        d = rand_pkt();
        push_pkt(d);
        base = xfer_cnt;
        tick();
        pkt_data = d;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        for (int i = 0; i < 30 && xfer_cnt < base + 3; i++) @(posedge clk);
        #1;
        ft_if.ui_din_full = 1'b1;
        @(negedge clk);
        held = {ft_if.ui_din, ft_if.ui_din_be};
        checks++;
        if (xfer_cnt != base + 3) begin failures++; $display("FAIL stall_setup got=%0d required=%0d", xfer_cnt - base, 3); end
        checks++;
        if (held !== {d[55:40], 2'b11}) begin failures++; $display("FAIL stall_word got=%h required=%h", held, {d[55:40], 2'b11}); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({ft_if.ui_din, ft_if.ui_din_be, ft_if.ui_din_valid} !== {held, 1'b1}) begin
                failures++;
                $display("FAIL stall_hold[%0d] got=%h/%b required=%h/1", i,
                         {ft_if.ui_din, ft_if.ui_din_be}, ft_if.ui_din_valid, held);
            end
            if (i < 9) @(negedge clk);
        end
        @(posedge clk);
        #1;
        ft_if.ui_din_full = 1'b0;
        wait_drain(50);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL stall_drain left=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_arbitration();
        logic [87:0] d;
        // Both from reset: last_grant starts as PKT, so STAT goes first.
        d = rand_pkt();
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total_packets = 32'hCAFE_0001;
        mismatch_packets = 32'h0000_0077;
        pkt_data = d;
        pkt_valid = 1'b1;
        stat_req = 1'b1;
        push_stat(32'hCAFE_0001, 32'h0000_0077, 16'h0000);
        push_pkt(d);
        tick();
        pkt_valid = 1'b0;
        stat_req = 1'b0;
        wait_drain(100);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL arb_stat_first left=%0d required=0", exp_q.size()); end

        // A stats-only frame makes STAT the last grant; next tie goes to PKT.
        push_stat(32'h0000_0042, 32'h0000_0003, 16'h0000);
        tick();
        total_packets = 32'h0000_0042;
        mismatch_packets = 32'h0000_0003;
        stat_req = 1'b1;
        tick();
        stat_req = 1'b0;
        wait_drain(50);

        d = rand_pkt();
        push_pkt(d);
        push_stat(32'h0000_0099, 32'h0000_0004, 16'h0000);
        tick();
        total_packets = 32'h0000_0099;
        mismatch_packets = 32'h0000_0004;
        pkt_data = d;
        pkt_valid = 1'b1;
        stat_req = 1'b1;
        tick();
        pkt_valid = 1'b0;
        stat_req = 1'b0;
        wait_drain(100);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL arb_pkt_first left=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_drop();
        logic [87:0] d1;
        d1 = rand_pkt();
        apply_reset();
        ft_if.ui_din_full = 1'b1;
        total_packets = 32'h0001_0002;
        mismatch_packets = 32'h0003_0004;
        stat_req = 1'b1;
        tick();
        stat_req = 1'b0;
        tick();
        tick();
        // Stats header is stalled; first pulse is held, the next two drop.
        for (int i = 0; i < 3; i++) begin
            pkt_data = (i == 0) ? d1 : rand_pkt();
            pkt_valid = 1'b1;
            tick();
            pkt_valid = 1'b0;
            tick();
        end
        @(negedge clk);
        checks++;
        if (drop_count !== 16'd2) begin failures++; $display("FAIL drop_count got=%0d required=2", drop_count); end
        push_stat(32'h0001_0002, 32'h0003_0004, 16'd2);
        push_pkt(d1);
        tick();
        ft_if.ui_din_full = 1'b0;
        wait_drain(100);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL drop_drain left=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_saturate();
        logic [87:0] d;
        d = rand_pkt();
        apply_reset();
        ft_if.ui_din_full = 1'b1;
        push_pkt(d);
        pkt_data = d;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        repeat (3) tick();
        pkt_data = rand_pkt();
        pkt_valid = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        checks++;
        if (drop_count !== 16'd1000) begin failures++; $display("FAIL drop_mid got=%0d required=1000", drop_count); end
        repeat (69000) @(posedge clk);
        #1;
        pkt_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (drop_count !== 16'hFFFF) begin failures++; $display("FAIL drop_sat got=%h required=ffff", drop_count); end
        tick();
        ft_if.ui_din_full = 1'b0;
        wait_drain(50);
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL sat_drain left=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_rst_mid_frame();
        logic [87:0] d;
        int base;
        int stray;
        d = rand_pkt();
        push_pkt(d);
        base = xfer_cnt;
        tick();
        pkt_data = d;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        for (int i = 0; i < 30 && xfer_cnt < base + 3; i++) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (ft_if.ui_din_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b required=0", ft_if.ui_din_valid); end
        checks++;
        if (drop_count !== 16'h0000) begin failures++; $display("FAIL rst_mid_drop got=%h required=0000", drop_count); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b required=0", busy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ft_if.ui_din_valid) stray++;
        end
        checks++;
        if (stray != 0) begin failures++; $display("FAIL rst_mid_stray got=%0d required=0", stray); end
    endtask

    task automatic test_periodic();
        int hdr[4];
        int nh;
        logic prev;
        nh = 0;
        prev = 1'b0;
        for (int k = 0; k < 4; k++) hdr[k] = 0;
        for (int i = 0; i < 600 && nh < 4; i++) begin
            @(negedge clk);
            if (ft_if_p.ui_din_valid && !prev && ft_if_p.ui_din == HS) begin
                hdr[nh] = cyc;
                nh++;
            end
            prev = ft_if_p.ui_din_valid;
        end
        checks++;
        if (nh != 4) begin failures++; $display("FAIL periodic_count got=%0d required=4", nh); end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (hdr[k] - hdr[k-1] != 100) begin
                failures++;
                $display("FAIL periodic_gap[%0d] got=%0d required=100", k, hdr[k] - hdr[k-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pkt();
        test_stat();
        test_stall();
        test_arbitration();
        test_drop();
        test_saturate();
        test_rst_mid_frame();
        test_periodic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        failures++;
        $display("FAIL watchdog time=%0t required=finish", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
